// File: rtl/matriz_pkg.sv
`default_nettype none
// ============================================================================
// Module      : matriz_pkg
// Description : Shared constants for the LED matrix scan controller: FSM
//               state encoding, row geometry and default scan timing.
// Revision    : 1.0 - initial release
// ============================================================================
package matriz_pkg;

  // Matrix geometry: eight rows addressed by a three-bit row index.
  localparam int ROW_COUNT = 8;
  localparam int ROW_W     = 3;

  // Default timing: 1 kHz frame refresh at 50 MHz with eight rows.
  localparam int DEF_DRIVE_CYCLES = 6250;
  localparam int DEF_BLANK_CYCLES = 50;

  // Scan FSM state encoding.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_DRIVE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/matriz_frame_buf.sv
`default_nettype none
// ============================================================================
// Module      : matriz_frame_buf
// Description : Double-buffered row storage (2 x ROWS x DATAWIDTH) with one
//               write port and one registered read port. The read port
//               returns the contents the array holds after the current edge,
//               so a write and a read of the same entry on one edge yield the
//               newly written data.
// Revision    : 1.0 - initial release
// ============================================================================
module matriz_frame_buf
  import matriz_pkg::*;
#(
  parameter int DATAWIDTH = ROW_COUNT,
  parameter int ROWS      = ROW_COUNT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic                 wr_buf,
  input  logic [ROW_W-1:0]     wr_addr,
  input  logic [DATAWIDTH-1:0] wr_data,
  input  logic                 rd_en,
  input  logic                 rd_buf,
  input  logic [ROW_W-1:0]     rd_addr,
  output logic [DATAWIDTH-1:0] rd_data
);

  logic [DATAWIDTH-1:0] mem [2][ROWS];
  logic                 fwd_hit;

  assign fwd_hit = wr_en && (wr_buf == rd_buf) && (wr_addr == rd_addr);

  // Storage array: cleared in reset, otherwise one row written per strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < ROWS; r++) begin
          mem[b][r] <= '0;
        end
      end
    end else if (wr_en) begin
      mem[wr_buf][wr_addr] <= wr_data;
    end
  end

  // Registered read: zero when not enabled, forwarded data on a same-edge hit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (!rd_en) begin
      rd_data <= '0;
    end else if (fwd_hit) begin
      rd_data <= wr_data;
    end else begin
      rd_data <= mem[rd_buf][rd_addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/matriz_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : matriz_scan_ctrl
// Description : Multiplexed LED matrix scanner. Cycles through the rows with
//               a blanking gap before each row, displays the front buffer and
//               swaps front/back buffers only at frame boundaries (or at once
//               while idle). All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module matriz_scan_ctrl
  import matriz_pkg::*;
#(
  parameter int DATAWIDTH    = ROW_COUNT,
  parameter int DRIVE_CYCLES = DEF_DRIVE_CYCLES,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
  input  logic                 MatrizScan_CLOCK_50,
  input  logic                 MatrizScan_RESET_InLow,
  input  logic                 MatrizScan_Enable_In,
  input  logic                 MatrizScan_WrEn_In,
  input  logic [ROW_W-1:0]     MatrizScan_WrAddr_In,
  input  logic [DATAWIDTH-1:0] MatrizScan_WrData_In,
  input  logic                 MatrizScan_Swap_In,
  output logic                 MatrizScan_SwapAck_Out,
  output logic [DATAWIDTH-1:0] MatrizScan_Row_Out,
  output logic [DATAWIDTH-1:0] MatrizScan_Col_Out,
  output logic                 MatrizScan_FrameStart_Out
);

  localparam int CNT_MAX = (DRIVE_CYCLES > BLANK_CYCLES) ? DRIVE_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DRIVE_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(DATAWIDTH - 1);

  // With no blanking configured, each row goes straight into DRIVE.
  localparam logic [1:0] ST_ROW_ENTRY = (BLANK_CYCLES > 0) ? ST_BLANK : ST_DRIVE;

  logic                 clk;
  logic                 rst_n;
  logic                 enable;

  logic [1:0]           state,   state_nxt;
  logic [ROW_W-1:0]     row,     row_nxt;
  logic [CNT_W-1:0]     cnt,     cnt_nxt;
  logic                 sel,     sel_nxt;
  logic                 pending, pending_nxt;
  logic                 commit;
  logic                 frame_start_nxt;

  logic [DATAWIDTH-1:0] row_sel;
  logic                 frame_start;
  logic                 swap_ack;
  logic [DATAWIDTH-1:0] col_data;

  assign clk    = MatrizScan_CLOCK_50;
  assign rst_n  = MatrizScan_RESET_InLow;
  assign enable = MatrizScan_Enable_In;

  // Next-state, row/counter advance, frame marker and swap commit decision.
  always_comb begin
    state_nxt       = state;
    row_nxt         = row;
    cnt_nxt         = cnt;
    frame_start_nxt = 1'b0;
    commit          = 1'b0;

    case (state)
      ST_IDLE: begin
        // Nothing is on screen, so a pending swap can take effect at once.
        commit = pending;
        if (enable) begin
          state_nxt       = ST_ROW_ENTRY;
          row_nxt         = '0;
          cnt_nxt         = '0;
          frame_start_nxt = 1'b1;
        end
      end
      ST_BLANK: begin
        if (cnt == BLANK_LAST) begin
          state_nxt = ST_DRIVE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_DRIVE: begin
        if (cnt == DRIVE_LAST) begin
          state_nxt = ST_ROW_ENTRY;
          cnt_nxt   = '0;
          if (row == LAST_ROW) begin
            // Frame boundary: the only point where a running display swaps.
            row_nxt         = '0;
            frame_start_nxt = 1'b1;
            commit          = pending;
          end else begin
            row_nxt = row + ROW_W'(1);
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        row_nxt   = '0;
        cnt_nxt   = '0;
      end
    endcase

    // Disable overrides the scan but leaves buffers and the pending request.
    if (!enable) begin
      state_nxt       = ST_IDLE;
      row_nxt         = '0;
      cnt_nxt         = '0;
      frame_start_nxt = 1'b0;
    end

    // A request in the commit cycle itself re-arms for the following frame.
    sel_nxt     = sel ^ commit;
    pending_nxt = MatrizScan_Swap_In | (pending & ~commit);
  end

  // Scan state, buffer select and registered row/marker outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      row         <= '0;
      cnt         <= '0;
      sel         <= 1'b0;
      pending     <= 1'b0;
      row_sel     <= '0;
      frame_start <= 1'b0;
      swap_ack    <= 1'b0;
    end else begin
      state       <= state_nxt;
      row         <= row_nxt;
      cnt         <= cnt_nxt;
      sel         <= sel_nxt;
      pending     <= pending_nxt;
      row_sel     <= (state_nxt == ST_DRIVE) ? (DATAWIDTH'(1) << row_nxt) : '0;
      frame_start <= frame_start_nxt;
      swap_ack    <= commit;
    end
  end

  // Writes always target the pre-commit back buffer; the read port fetches
  // the row being driven next cycle from the post-commit front buffer.
  matriz_frame_buf #(
    .DATAWIDTH (DATAWIDTH),
    .ROWS      (DATAWIDTH)
  ) u_frame_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (MatrizScan_WrEn_In),
    .wr_buf  (~sel),
    .wr_addr (MatrizScan_WrAddr_In),
    .wr_data (MatrizScan_WrData_In),
    .rd_en   (state_nxt == ST_DRIVE),
    .rd_buf  (sel_nxt),
    .rd_addr (row_nxt),
    .rd_data (col_data)
  );

  assign MatrizScan_Row_Out        = row_sel;
  assign MatrizScan_Col_Out        = col_data;
  assign MatrizScan_FrameStart_Out = frame_start;
  assign MatrizScan_SwapAck_Out    = swap_ack;

endmodule
`default_nettype wire

// File: tb/tb_matriz_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_matriz_scan_ctrl
// Description : Self-checking bench for matriz_scan_ctrl with short timing
//               (DRIVE=4, BLANK=2). A frame-position reference model predicts
//               every output cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matriz_scan_ctrl;

  localparam int B = 2;
  localparam int D = 4;
  localparam int S = B + D;
  localparam int P = 8 * S;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       swap = 1'b0;
  logic       swap_ack;
  logic [7:0] row_out;
  logic [7:0] col_out;
  logic       frame_start;

  int checks = 0;
  int errors = 0;

  // Reference model: scan position as a cycle count since enable.
  bit         m_active = 1'b0;
  int         m_t = 0;
  bit         m_sel = 1'b0;
  bit         m_pend = 1'b0;
  bit         m_ack = 1'b0;
  logic [7:0] m_mem [2][8];

  matriz_scan_ctrl #(
    .DATAWIDTH    (8),
    .DRIVE_CYCLES (D),
    .BLANK_CYCLES (B)
  ) dut (
    .MatrizScan_CLOCK_50       (clk),
    .MatrizScan_RESET_InLow    (rst_n),
    .MatrizScan_Enable_In      (enable),
    .MatrizScan_WrEn_In        (wr_en),
    .MatrizScan_WrAddr_In      (wr_addr),
    .MatrizScan_WrData_In      (wr_data),
    .MatrizScan_Swap_In        (swap),
    .MatrizScan_SwapAck_Out    (swap_ack),
    .MatrizScan_Row_Out        (row_out),
    .MatrizScan_Col_Out        (col_out),
    .MatrizScan_FrameStart_Out (frame_start)
  );

  always #5 clk = ~clk;

  function automatic void model_edge(input bit en, input bit we, input logic [2:0] wa,
                                     input logic [7:0] wd, input bit sw, input bit rn);
    bit commit;
    if (!rn) begin
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < 8; r++) m_mem[b][r] = 8'h00;
      m_active = 0; m_t = 0; m_sel = 0; m_pend = 0; m_ack = 0;
      return;
    end
    commit = m_pend && (!m_active || (m_t % P == P - 1));
    if (we) m_mem[!m_sel][wa] = wd;
    m_sel  = m_sel ^ commit;
    m_pend = sw || (m_pend && !commit);
    m_ack  = commit;
    if (!en) begin
      m_active = 0; m_t = 0;
    end else if (!m_active) begin
      m_active = 1; m_t = 0;
    end else begin
      m_t++;
    end
  endfunction

  // Expected {row, col, frame_start, swap_ack} for the current cycle.
  function automatic logic [17:0] exp_out();
    logic [7:0] r = 8'h00;
    logic [7:0] c = 8'h00;
    logic       fs = 1'b0;
    int pos, rr, ph;
    if (m_active) begin
      pos = m_t % P;
      rr  = pos / S;
      ph  = pos % S;
      if (ph >= B) begin
        r = 8'(1 << rr);
        c = m_mem[m_sel][rr];
      end
      fs = (pos == 0);
    end
    return {r, c, fs, m_ack};
  endfunction

  function automatic bit in_drive(input int r);
    return m_active && ((m_t % P) / S == r) && ((m_t % P) % S >= B);
  endfunction

  task automatic tick(input bit en, input bit we, input logic [2:0] wa,
                      input logic [7:0] wd, input bit sw, input bit rn);
    enable = en; wr_en = we; wr_addr = wa; wr_data = wd; swap = sw; rst_n = rn;
    @(posedge clk);
    model_edge(en, we, wa, wd, sw, rn);
    #1;
  endtask

  task automatic test_reset();
    logic [17:0] e;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b1, 3'(i), 8'($urandom), 1'b1, 1'b0);
      e = exp_out();
      checks++;
      if ({row_out, col_out, frame_start, swap_ack} !== e) begin
        errors++;
        $display("FAIL reset cyc%0d got=%h exp=%h", i, {row_out, col_out, frame_start, swap_ack}, e);
      end
    end
  endtask

  task automatic test_frame_timing();
    logic [7:0]  tbl [10];
    logic [17:0] e;
    tbl = '{8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 8'h02, 8'h02};
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1);
      checks++;
      if (row_out !== tbl[i] || frame_start !== (i == 0)) begin
        errors++;
        $display("FAIL timing cyc%0d got row=%h fs=%b exp row=%h fs=%b", i, row_out, frame_start, tbl[i], i == 0);
      end
    end
    for (int i = 0; i < 40; i++) begin
      tick(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1);
      e = exp_out();
      checks++;
      if ({row_out, col_out, frame_start, swap_ack} !== e) begin
        errors++;
        $display("FAIL timing_model cyc%0d got=%h exp=%h", i, {row_out, col_out, frame_start, swap_ack}, e);
      end
    end
  endtask

  task automatic test_swap();
    logic [17:0] e;
    int acks = 0;
    int nonzero_before = 0;
    int n;
    for (int i = 0; i < 8; i++) tick(1'b1, 1'b1, 3'(i), 8'hA5, 1'b0, 1'b1);
    n = 0;
    while (!in_drive(3) && n < 2 * P) begin tick(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1); n++; end
    tick(1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1);
    n = 0;
    while (acks == 0 && n < 2 * P) begin
      tick(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1);
      n++;
      if (swap_ack) begin
        acks++;
        checks++;
        if (frame_start !== 1'b1 || row_out !== 8'h00) begin
          errors++;
          $display("FAIL swap_ack_position got fs=%b row=%h exp fs=1 row=00", frame_start, row_out);
        end
      end else if (col_out !== 8'h00) begin
        nonzero_before++;
      end
      e = exp_out();
      checks++;
      if ({row_out, col_out, frame_start, swap_ack} !== e) begin
        errors++;
        $display("FAIL swap_model cyc%0d got=%h exp=%h", n, {row_out, col_out, frame_start, swap_ack}, e);
      end
    end
    checks++;
    if (acks != 1 || nonzero_before != 0) begin
      errors++;
      $display("FAIL swap_ack_count got acks=%0d old_nonzero=%0d exp acks=1 old_nonzero=0", acks, nonzero_before);
    end
    n = 0;
    while (row_out !== 8'h01 && n < P) begin tick(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1); n++; end
    checks++;
    if (col_out !== 8'hA5) begin
      errors++;
      $display("FAIL swap_new_front got col=%h exp col=a5", col_out);
    end
  endtask

  task automatic test_swap_held();
    logic [17:0] e;
    int acks = 0;
    int n = 0;
    while (!(m_active && m_t % P == 0) && n < 2 * P) begin tick(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1); n++; end
    for (int i = 1; i <= 3 * P; i++) begin
      tick(1'b1, 1'b1, 3'($urandom), 8'($urandom), 1'b1, 1'b1);
      if (swap_ack) acks++;
      e = exp_out();
      checks++;
      if ({row_out, col_out, frame_start, swap_ack} !== e) begin
        errors++;
        $display("FAIL held_model cyc%0d got=%h exp=%h", i, {row_out, col_out, frame_start, swap_ack}, e);
      end
    end
    checks++;
    if (acks != 3) begin
      errors++;
      $display("FAIL held_ack_count got=%0d exp=3", acks);
    end
  endtask

  task automatic test_enable_drop();
    logic [17:0] e;
    int n = 0;
    while (!in_drive(5) && n < 2 * P) begin tick(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1); n++; end
    tick(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (row_out !== 8'h00 || col_out !== 8'h00) begin
      errors++;
      $display("FAIL drop_blank got row=%h col=%h exp row=00 col=00", row_out, col_out);
    end
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      tick(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1);
      if (i == 0) begin
        checks++;
        if (frame_start !== 1'b1) begin
          errors++;
          $display("FAIL reenable_fs got=%b exp=1", frame_start);
        end
      end
      e = exp_out();
      checks++;
      if ({row_out, col_out, frame_start, swap_ack} !== e) begin
        errors++;
        $display("FAIL reenable_model cyc%0d got=%h exp=%h", i, {row_out, col_out, frame_start, swap_ack}, e);
      end
    end
  endtask

  task automatic test_commit_write();
    int acks = 0;
    int hits = 0;
    int n = 0;
    tick(1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1);
    while (!(m_active && m_pend && m_t % P == P - 1) && n < 2 * P) begin
      tick(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1); n++;
    end
    tick(1'b1, 1'b1, 3'd2, 8'h3C, 1'b1, 1'b1);
    checks++;
    if (swap_ack !== 1'b1) begin
      errors++;
      $display("FAIL commit_ack got=%b exp=1", swap_ack);
    end
    for (int i = 1; i <= P; i++) begin
      tick(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1);
      if (swap_ack) acks++;
      if (row_out === 8'h04 && col_out === 8'h3C) hits++;
    end
    checks++;
    if (hits != D || acks != 1) begin
      errors++;
      $display("FAIL commit_write got row2_hits=%0d acks=%0d exp row2_hits=%0d acks=1", hits, acks, D);
    end
  endtask

  task automatic test_random();
    logic [17:0] e;
    for (int i = 0; i < 500; i++) begin
      tick(($urandom % 20) != 0, ($urandom % 3) == 0, 3'($urandom), 8'($urandom),
           ($urandom % 40) == 0, 1'b1);
      e = exp_out();
      checks++;
      if ({row_out, col_out, frame_start, swap_ack} !== e) begin
        errors++;
        $display("FAIL random cyc%0d got=%h exp=%h", i, {row_out, col_out, frame_start, swap_ack}, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    int nonzero = 0;
    int rows_seen = 0;
    int n = 0;
    while (!in_drive(6) && n < 3 * P) begin tick(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1); n++; end
    tick(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    checks++;
    if ({row_out, col_out, frame_start, swap_ack} !== 18'h0) begin
      errors++;
      $display("FAIL reset_mid got=%h exp=00000", {row_out, col_out, frame_start, swap_ack});
    end
    tick(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < P; i++) begin
      tick(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1);
      if (i == 0) begin
        checks++;
        if (frame_start !== 1'b1 || row_out !== 8'h00) begin
          errors++;
          $display("FAIL reset_restart got fs=%b row=%h exp fs=1 row=00", frame_start, row_out);
        end
      end
      if (col_out !== 8'h00) nonzero++;
      if (row_out !== 8'h00) rows_seen++;
    end
    checks++;
    if (nonzero != 0 || rows_seen != 8 * D) begin
      errors++;
      $display("FAIL reset_cleared got col_nonzero=%0d drive_cycles=%0d exp 0 and %0d", nonzero, rows_seen, 8 * D);
    end
  endtask

  initial begin
    test_reset();
    test_frame_timing();
    test_swap();
    test_swap_held();
    test_enable_drop();
    test_commit_write();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
